// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state type and colour-bar geometry for the VGA scan controller.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int RD_LAT   = 3;
  localparam int ADDR_W   = 19;
  localparam int BAR_W    = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset to a caller-chosen idle value.
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster generator and frame-buffer fetch initiator; re-aligns sync/blank to returned pixels.
// Build option TEST_PATTERN_EN adds internal 8-bar colour pattern selected by test_mode.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int RD_LAT   = vga_pkg::RD_LAT,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_ready,
  input  logic              test_mode,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  output logic [ADDR_W-1:0] vga_addr,
  output logic              vga_flag,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_done
);
  import vga_pkg::*;

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state, state_nxt;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [ADDR_W-1:0] addr;
  logic              h_end, v_end, frame_end, running;
  logic              de_raw, hs_raw, vs_raw;

  assign h_end     = (hcnt == HW'(H_TOT - 1));
  assign v_end     = (vcnt == VW'(V_TOT - 1));
  assign frame_end = h_end && v_end;
  assign running   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // LAST keeps sweeping so a frame is never cut short by img_ready falling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (img_ready) state_nxt = RUN;
      RUN:     if (!img_ready) state_nxt = LAST;
      LAST:    if (img_ready) state_nxt = RUN;
               else if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !running) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end) begin
      hcnt <= '0;
      vcnt <= v_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign de_raw = running && (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hs_raw = !((hcnt >= HW'(HS_START)) && (hcnt < HW'(HS_END)));
  assign vs_raw = !((vcnt >= VW'(VS_START)) && (vcnt < VW'(VS_END)));

  // Running pixel index: advances only on visible pixels and wraps after the last one.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      addr <= '0;
    end else if (frame_end) begin
      addr <= '0;
    end else if (de_raw) begin
      addr <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
    end
  end

  assign vga_addr   = de_raw ? addr : '0;
  assign vga_flag   = running;
  assign frame_done = running && frame_end;
  assign vga_sync_n = 1'b0;

`ifdef TEST_PATTERN_EN
  localparam int PW = 6;
  localparam logic [PW-1:0] PIPE_RST = 6'b011000;
  logic [2:0]    bar_raw, bar_d;
  logic [PW-1:0] pipe_in, pipe_out;
  logic          de_d, hs_d, vs_d;
  assign bar_raw = 3'(hcnt / HW'(BAR_W));
  assign pipe_in = {de_raw, hs_raw, vs_raw, bar_raw};
  assign {de_d, hs_d, vs_d, bar_d} = pipe_out;
`else
  localparam int PW = 3;
  localparam logic [PW-1:0] PIPE_RST = 3'b011;
  logic [PW-1:0] pipe_in, pipe_out;
  logic          de_d, hs_d, vs_d;
  logic          test_mode_unused;
  assign test_mode_unused = test_mode;
  assign pipe_in = {de_raw, hs_raw, vs_raw};
  assign {de_d, hs_d, vs_d} = pipe_out;
`endif

  vga_delay_line #(
    .W       (PW),
    .D       (RD_LAT),
    .RST_VAL (PIPE_RST)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  // Output stage: the same edge captures returned pixel data and its delayed timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_blank_n <= de_d;
      if (!de_d) begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end else begin
`ifdef TEST_PATTERN_EN
        if (test_mode) begin
          vga_r <= {8{bar_d[2]}};
          vga_g <= {8{bar_d[1]}};
          vga_b <= {8{bar_d[0]}};
        end else begin
          vga_r <= red_in;
          vga_g <= green_in;
          vga_b <= blue_in;
        end
`else
        vga_r <= red_in;
        vga_g <= green_in;
        vga_b <= blue_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: frame-position reference model plus directed timing checks.
// Vertical timing is shortened (6 visible lines, 12 total) so several whole frames fit the run.
module tb_vga_scan_ctrl;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;
  localparam int MAX_ADDR = HA * VA - 1;

  logic        clk, rst, img_ready, test_mode;
  logic [7:0]  red_in, green_in, blue_in;
  logic [18:0] vga_addr;
  logic        vga_flag, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_done;
  logic [7:0]  vga_r, vga_g, vga_b;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [18:0] addr;
    logic [9:0]  x;
  } raw_t;

  localparam raw_t RST_ENT = '{de: 1'b0, hs: 1'b1, vs: 1'b1, addr: '0, x: '0};

  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   fd_q[$], vs_fall_q[$];
  int   max_cnt = 0, vs_len = -1;
  logic prev_vs = 1'b1;
  int   m_st = 0, m_pos = 0;
  logic tm;
  raw_t hist[4];
  logic [18:0] mem_hist[3];

  vga_scan_ctrl #(
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk (clk), .rst (rst), .img_ready (img_ready), .test_mode (test_mode),
    .red_in (red_in), .green_in (green_in), .blue_in (blue_in),
    .vga_addr (vga_addr), .vga_flag (vga_flag), .vga_hs (vga_hs), .vga_vs (vga_vs),
    .vga_blank_n (vga_blank_n), .vga_sync_n (vga_sync_n),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b), .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks frame position and derives every output from screen coordinates.
  always begin : model_and_compare
    raw_t        cur, al;
    int          x, y, bi;
    logic        on;
    logic [23:0] e_rgb;
    logic [54:0] e_vec, a_vec;
    logic [18:0] ma;
    @(posedge clk);
    cyc++;
    tm = test_mode;
    if (rst) begin
      m_st = 0;
      m_pos = 0;
      for (int k = 0; k < 4; k++) hist[k] = RST_ENT;
    end else begin
      case (m_st)
        0: if (img_ready) m_st = 1;
        1: begin
          if (!img_ready) m_st = 2;
          m_pos = (m_pos + 1) % FRAME;
        end
        default: begin
          if (img_ready) m_st = 1;
          else if (m_pos == FRAME - 1) m_st = 0;
          m_pos = (m_pos + 1) % FRAME;
        end
      endcase
    end
    #1;
    x = m_pos % HT;
    y = m_pos / HT;
    on = (m_st != 0);
    cur.de   = on && x < HA && y < VA;
    cur.hs   = !(on && x >= HA + HF && x < HA + HF + HS);
    cur.vs   = !(on && y >= VA + VF && y < VA + VF + VS);
    cur.addr = cur.de ? 19'(y * HA + x) : 19'd0;
    cur.x    = 10'(x);
    al = hist[3];
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = cur;
    if (!al.de) begin
      e_rgb = 24'h0;
    end else begin
      e_rgb = {al.addr[7:0], al.addr[15:8], 5'b0, al.addr[18:16]};
`ifdef TEST_PATTERN_EN
      if (tm) begin
        bi = int'(al.x) / 80;
        e_rgb = {bi[2] ? 8'hFF : 8'h00, bi[1] ? 8'hFF : 8'h00, bi[0] ? 8'hFF : 8'h00};
      end
`endif
    end
    e_vec = {cur.addr, on, on && m_pos == FRAME - 1, al.hs, al.vs, al.de, 1'b0, e_rgb};
    a_vec = {vga_addr, vga_flag, frame_done, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
             vga_r, vga_g, vga_b};
    n_chk++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL cycle_outputs @%0d: got addr=%0d flag=%b fd=%b hs=%b vs=%b blank_n=%b sync_n=%b rgb=%h expected addr=%0d flag=%b fd=%b hs=%b vs=%b blank_n=%b sync_n=0 rgb=%h",
               cyc, vga_addr, vga_flag, frame_done, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               {vga_r, vga_g, vga_b}, cur.addr, on, on && m_pos == FRAME - 1, al.hs, al.vs,
               al.de, e_rgb);
    end
    // Frame-buffer stand-in: data for an address shows up RD_LAT clocks after it is issued.
    ma = mem_hist[2];
    red_in   = ma[7:0];
    green_in = ma[15:8];
    blue_in  = {5'b0, ma[18:16]};
    mem_hist[2] = mem_hist[1];
    mem_hist[1] = mem_hist[0];
    mem_hist[0] = vga_addr;
  end

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_done) fd_q.push_back(cyc);
      if (vga_flag && vga_addr == 19'(MAX_ADDR)) max_cnt++;
      if (prev_vs && !vga_vs) vs_fall_q.push_back(cyc);
      if (!prev_vs && vga_vs && vs_fall_q.size() > 0) vs_len = cyc - vs_fall_q[$];
      prev_vs = vga_vs;
    end
  endtask

  task automatic wait_cyc(input int target);
    if (target > cyc) run_cycles(target - cyc);
  endtask

  task automatic wait_hs(input logic level, output int c);
    int n;
    n = 0;
    while (vga_hs !== level && n < 2000) begin
      @(negedge clk);
      n++;
    end
    c = (vga_hs === level) ? cyc : -1;
  endtask

  int xs[6] = '{0, 79, 80, 159, 560, 639};
`ifdef TEST_PATTERN_EN
  logic [23:0] bar_exp[6] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF};
`else
  logic [23:0] bar_exp[6] = '{24'h000000, 24'h4F0000, 24'h500000, 24'h9F0000, 24'h300200, 24'h7F0200};
`endif

  initial begin
    int t0, t1, t2, c_fall, c_rise, c_fall2, v;
    rst = 1'b1;
    img_ready = 1'b0;
    test_mode = 1'b0;
    red_in = '0;
    green_in = '0;
    blue_in = '0;
    for (int k = 0; k < 3; k++) mem_hist[k] = '0;

    repeat (5) @(negedge clk);
    chk("reset_hs", vga_hs, 1);
    chk("reset_vs", vga_vs, 1);
    chk("reset_blank_n", vga_blank_n, 0);
    chk("reset_addr_flag", {vga_addr, vga_flag}, 0);
    chk("reset_rgb_fd", {vga_r, vga_g, vga_b, frame_done}, 0);

    rst = 1'b0;
    run_cycles(1);
    chk("idle_flag", vga_flag, 0);

    img_ready = 1'b1;
    run_cycles(1);
    t0 = cyc;
    chk("first_addr", vga_addr, 0);
    chk("first_flag", vga_flag, 1);
    run_cycles(1);
    chk("second_addr", vga_addr, 1);

    wait_hs(1'b0, c_fall);
    chk("hs_fall_offset", c_fall - t0, 656 + LAT + 1);
    wait_hs(1'b1, c_rise);
    chk("hs_low_width", c_rise - c_fall, 96);
    wait_hs(1'b0, c_fall2);
    chk("line_period", c_fall2 - c_fall, 800);

    wait_cyc(t0 + 2 * FRAME + 260);
    v = (fd_q.size() > 0) ? fd_q[0] - t0 : -1;
    chk("first_frame_done", v, FRAME - 1);
    v = (fd_q.size() > 1) ? fd_q[1] - fd_q[0] : -1;
    chk("frame_done_period", v, FRAME);
    chk("frame_done_count", fd_q.size(), 2);
    chk("addr_max_count", max_cnt, 2);
    v = (vs_fall_q.size() > 0) ? vs_fall_q[0] - t0 : -1;
    chk("vs_fall_offset", v, (VA + VF) * HT + LAT + 1);
    chk("vs_low_width", vs_len, VS * HT);

    fd_q.delete();
    wait_cyc(t0 + 2 * FRAME + 3 * HT);
    img_ready = 1'b0;
    wait_cyc(t0 + 3 * FRAME + 10);
    v = (fd_q.size() > 0) ? fd_q[0] - t0 : -1;
    chk("drop_frame_done", v, 3 * FRAME - 1);
    chk("drop_frame_count", fd_q.size(), 1);
    chk("drop_frame_max", max_cnt, 3);
    chk("drop_idle_flag", vga_flag, 0);
    run_cycles(50);
    chk("idle_static", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, vga_addr}, {2'b11, 1'b0, 24'h0, 19'h0});

    img_ready = 1'b1;
    run_cycles(1);
    t1 = cyc;
    chk("restart_addr", vga_addr, 0);
    chk("restart_flag", vga_flag, 1);

    wait_cyc(t1 + 4 * HT + 300);
    chk("mid_addr", vga_addr, 4 * HA + 300);
    rst = 1'b1;
    run_cycles(1);
    chk("midrst_hs_vs", {vga_hs, vga_vs}, 2'b11);
    chk("midrst_r", vga_r, 0);
    chk("midrst_addr", vga_addr, 0);
    chk("midrst_flag", vga_flag, 0);

    rst = 1'b0;
    test_mode = 1'b1;
    run_cycles(1);
    t2 = cyc;
    chk("bars_start_flag", vga_flag, 1);
    for (int k = 0; k < 6; k++) begin
      wait_cyc(t2 + xs[k] + LAT + 1);
      chk($sformatf("pixel_x%0d_rgb", xs[k]), {vga_r, vga_g, vga_b}, bar_exp[k]);
    end
    run_cycles(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
